// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg: shared types and default sizes for the ADC receive controller.
//   rx_state_e  - controller states
//   rx_entry_t  - FIFO entry layout {last, data} at the default data width
package rx_ctrl_pkg;

   localparam int RX_DW      = 32;
   localparam int RX_CW      = 16;
   localparam int RX_FIFO_AW = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DELAY   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } rx_state_e;

   // Entry layout: bit DW is the record-last flag, bits DW-1:0 the sample.
   typedef struct packed {
      logic              last;
      logic [RX_DW-1:0]  data;
   } rx_entry_t;

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous first-word fall-through FIFO, depth 2**AW, width W.
// A word written in cycle N is visible on rd_data in cycle N+1.
//   clk, rstn  - clock, async active-low reset
//   wr_en      - push wr_data (ignored when full unless a pop happens too)
//   rd_en      - pop the head (ignored when empty)
//   rd_data    - current head entry
//   empty      - no entries held
//   count      - occupancy, 0..2**AW
module rx_fifo
#(
   parameter int W  = 33,
   parameter int AW = 4
)
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(1 << AW);

   logic [W-1:0]  mem [0:(1<<AW)-1];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign do_rd   = rd_en && (count != '0);
   assign do_wr   = wr_en && ((count != FULL_LVL) || do_rd);
   assign rd_data = mem[rd_ptr];
   assign empty   = (count == '0);

   // Storage carries no reset; the consumer gates data with empty.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rx_ctrl.sv
// rx_ctrl: on an accepted trig, waits rxdly cycles then captures rxsmps
// consecutive adc_data words and streams them out over AXI-Stream with
// m_tlast on the final word of the record.
//   clk, rstn            - ADC fabric clock, async active-low reset
//   trig                 - single-cycle capture request
//   rxsmps, rxdly        - samples per record / trig-to-capture delay
//   adc_data             - ADC sample word, valid every cycle
//   m_tdata/tvalid/tlast - stream out, m_tready - stream ready in
//   busy                 - record in progress (trig accepted, last not yet taken)
//   ovf                  - sticky: a sample was dropped in this or previous record
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for trig with rxsmps != 0
// ST_DELAY   | dly_cnt counting down the trig-to-capture delay
// ST_CAPTURE | one sample per cycle, smp_cnt counting down to the final word
// ST_DRAIN   | waiting for the tlast handshake
module rx_ctrl
   import rx_ctrl_pkg::*;
#(
   parameter int DW      = RX_DW,
   parameter int CW      = RX_CW,
   parameter int FIFO_AW = RX_FIFO_AW
)
(
   input  logic           clk,
   input  logic           rstn,
   input  logic           trig,
   input  logic [CW-1:0]  rxsmps,
   input  logic [CW-1:0]  rxdly,
   input  logic [DW-1:0]  adc_data,
   output logic [DW-1:0]  m_tdata,
   output logic           m_tvalid,
   output logic           m_tlast,
   input  logic           m_tready,
   output logic           busy,
   output logic           ovf
);

   // Non-final words stop one slot short of full so the final word always fits.
   localparam logic [FIFO_AW:0] RESERVE_LVL = (FIFO_AW+1)'((1 << FIFO_AW) - 1);

   rx_state_e        state;
   logic [CW-1:0]    dly_cnt;
   logic [CW-1:0]    smp_cnt;
   logic [FIFO_AW:0] fifo_count;
   logic             fifo_empty;
   logic [DW:0]      fifo_wr_data;
   logic [DW:0]      fifo_rd_data;
   logic             fifo_wr_en;
   logic             fifo_rd_en;
   logic             trig_ok;
   logic             cap_final;
   logic             cap_room;
   logic             last_hs;

   assign trig_ok      = trig && (rxsmps != '0);
   assign cap_final    = (state == ST_CAPTURE) && (smp_cnt == CW'(1));
   assign cap_room     = (fifo_count < RESERVE_LVL);
   assign fifo_wr_en   = (state == ST_CAPTURE) && (cap_final || cap_room);
   assign fifo_wr_data = {cap_final, adc_data};
   assign fifo_rd_en   = m_tready && !fifo_empty;
   assign last_hs      = m_tvalid && m_tready && m_tlast;

   assign m_tvalid = !fifo_empty;
   assign m_tdata  = fifo_empty ? '0 : fifo_rd_data[DW-1:0];
   assign m_tlast  = !fifo_empty && fifo_rd_data[DW];

   rx_fifo #(
      .W  (DW + 1),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (fifo_wr_en),
      .wr_data (fifo_wr_data),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         dly_cnt <= '0;
         smp_cnt <= '0;
         busy    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trig_ok) begin
                  dly_cnt <= rxdly;
                  smp_cnt <= rxsmps;
                  busy    <= 1'b1;
                  ovf     <= 1'b0;
                  state   <= (rxdly != '0) ? ST_DELAY : ST_CAPTURE;
               end
            end
            ST_DELAY: begin
               dly_cnt <= dly_cnt - 1'b1;
               if (dly_cnt == CW'(1)) state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // Index advances every cycle; a skipped write is a dropped sample.
               smp_cnt <= smp_cnt - 1'b1;
               if (!fifo_wr_en) ovf <= 1'b1;
               if (cap_final) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (last_hs) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_ctrl.sv
// tb_rx_ctrl: table-driven records, hand-written corner sequences and a
// randomized phase, all shadowed every cycle by a queue-based reference model.
module tb_rx_ctrl;
   import rx_ctrl_pkg::*;

   localparam int DW = 32;
   localparam int CW = 16;
   localparam int DEPTH = 16;

   typedef struct {
      int n;
      int d;
      int stall;
      bit toggle;
      int exp_words;
      bit exp_ovf;
   } rec_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          trig = 1'b0;
   logic [CW-1:0] rxsmps = '0;
   logic [CW-1:0] rxdly = '0;
   logic [DW-1:0] adc_data;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b0;
   logic          busy;
   logic          ovf;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   rx_entry_t got_q[$];

   // reference model state
   rx_entry_t mq[$];
   rx_entry_t exp_e;
   rx_entry_t push_e;
   bit        m_busy;
   bit        m_ovf;
   int        cap_start;
   int        cap_n;
   int        m_occ;
   int        m_idx;
   bit        m_pop;
   bit        m_pop_last;
   bit        hold_v;
   logic      hold_l;
   logic [DW-1:0] hold_d;

   rec_t tbl[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign adc_data = DW'(cyc);

   rx_ctrl dut (
      .clk      (clk),
      .rstn     (rstn),
      .trig     (trig),
      .rxsmps   (rxsmps),
      .rxdly    (rxdly),
      .adc_data (adc_data),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .busy     (busy),
      .ovf      (ovf)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input rec_t e, input int rel);
      if (e.toggle) return (rel % 2) == 0;
      return rel >= e.stall;
   endfunction

   // Reference model: record = capture window [start, start+n), words pushed
   // to a 16-deep queue while it holds fewer than 15, the final word always.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            mq.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
            cap_n  = 0;
            hold_v = 1'b0;
            check("reset_out", {m_tvalid, m_tlast, busy, ovf, m_tdata}, '0);
         end else begin
            exp_e = (mq.size() != 0) ? mq[0] : '0;
            check("model_out", {m_tvalid, m_tlast, busy, ovf, m_tdata},
                  {(mq.size() != 0), exp_e.last, m_busy, m_ovf, exp_e.data});
            if (hold_v)
               check("axi_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, hold_l, hold_d});
            hold_v = m_tvalid && !m_tready;
            hold_l = m_tlast;
            hold_d = m_tdata;
            if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});

            m_occ      = mq.size();
            m_pop      = m_tready && (m_occ > 0);
            m_pop_last = m_pop && mq[0].last;
            if (m_busy && cyc >= cap_start && cyc < cap_start + cap_n) begin
               m_idx = cyc - cap_start;
               push_e.last = (m_idx == cap_n - 1);
               push_e.data = adc_data;
               if (push_e.last || m_occ < DEPTH - 1) mq.push_back(push_e);
               else m_ovf = 1'b1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_pop_last) m_busy = 1'b0;
            else if (!m_busy && trig && rxsmps != 0) begin
               m_busy    = 1'b1;
               m_ovf     = 1'b0;
               cap_start = cyc + int'(rxdly) + 1;
               cap_n     = int'(rxsmps);
            end
         end
      end
   end

   task automatic run_rec(input rec_t e);
      int t0;
      int s;
      int idx;
      rx_entry_t want;
      got_q.delete();
      m_tready = rdy(e, 0);
      t0 = cyc;
      trig = 1'b1;
      rxsmps = CW'(e.n);
      rxdly = CW'(e.d);
      step();
      trig = 1'b0;
      check("rec_busy_set", busy, 1'b1);
      check("rec_ovf_clr", ovf, 1'b0);
      for (int rel = 1; rel < 3000 && busy; rel++) begin
         m_tready = rdy(e, rel);
         step();
      end
      check("rec_done", busy, 1'b0);
      check("rec_ovf", ovf, e.exp_ovf);
      check("rec_count", got_q.size(), e.exp_words);
      s = t0 + e.d + 1;
      foreach (got_q[j]) begin
         idx = (j < e.exp_words - 1) ? j : e.n - 1;
         want.last = (j == e.exp_words - 1);
         want.data = DW'(s + idx);
         check("rec_word", got_q[j], want);
      end
      m_tready = 1'b1;
      step();
      check("rec_ovf_hold", ovf, e.exp_ovf);
   endtask

   initial begin
      int t0;
      int cnt;
      int n;
      int d;
      int stall;
      rec_t e;

      //          n   d  stall toggle words ovf
      tbl[0] = '{ 4,  0,   0,  1'b0,   4, 1'b0};
      tbl[1] = '{ 3,  5,   0,  1'b0,   3, 1'b0};
      tbl[2] = '{40,  0,  60,  1'b0,  16, 1'b1};
      tbl[3] = '{ 8,  2,   0,  1'b1,   8, 1'b0};
      tbl[4] = '{16,  0, 100,  1'b0,  16, 1'b0};
      tbl[5] = '{17,  0, 100,  1'b0,  16, 1'b1};
      tbl[6] = '{ 1,  1,   0,  1'b0,   1, 1'b0};
      tbl[7] = '{20,  3,  10,  1'b0,  20, 1'b0};

      repeat (3) step();
      check("rst_tvalid", m_tvalid, 1'b0);
      check("rst_tdata", m_tdata, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      rstn = 1'b1;
      repeat (2) step();

      // exact timing, rxsmps=4 rxdly=0
      m_tready = 1'b1;
      t0 = cyc;
      trig = 1'b1; rxsmps = 16'd4; rxdly = 16'd0;
      step();
      trig = 1'b0;
      check("basic_t1", {busy, m_tvalid}, 2'b10);
      for (int k = 0; k < 4; k++) begin
         step();
         check("basic_word", {m_tvalid, m_tlast, m_tdata}, {1'b1, (k == 3), DW'(t0 + 1 + k)});
      end
      check("basic_busy_last", busy, 1'b1);
      step();
      check("basic_end", {busy, m_tvalid, ovf}, 3'b000);

      // exact timing, rxsmps=3 rxdly=5
      t0 = cyc;
      trig = 1'b1; rxsmps = 16'd3; rxdly = 16'd5;
      step();
      trig = 1'b0;
      while (cyc < t0 + 7) step();
      check("dly5_first", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, DW'(t0 + 6)});
      step(); step();
      check("dly5_last", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, DW'(t0 + 8)});
      step(); step();

      foreach (tbl[i]) run_rec(tbl[i]);

      // second trig while busy is ignored
      got_q.delete();
      m_tready = 1'b1;
      t0 = cyc;
      trig = 1'b1; rxsmps = 16'd5; rxdly = 16'd0;
      step();
      trig = 1'b0;
      step();
      trig = 1'b1;
      step();
      trig = 1'b0;
      for (int k = 0; k < 100 && busy; k++) step();
      check("dbl_done", busy, 1'b0);
      check("dbl_count", got_q.size(), 5);
      foreach (got_q[j])
         check("dbl_word", got_q[j], {(j == 4), DW'(t0 + 1 + j)});
      cnt = 0;
      repeat (10) begin
         if (m_tvalid) cnt++;
         step();
      end
      check("dbl_quiet", cnt, 0);

      // rxsmps=0 trig is ignored
      trig = 1'b1; rxsmps = 16'd0; rxdly = 16'd3;
      step();
      trig = 1'b0;
      cnt = 0;
      repeat (8) begin
         if (busy || m_tvalid) cnt++;
         step();
      end
      check("zero_trig", cnt, 0);

      // async reset mid-record, then a clean record
      m_tready = 1'b0;
      trig = 1'b1; rxsmps = 16'd40; rxdly = 16'd0;
      step();
      trig = 1'b0;
      repeat (24) step();
      check("pre_rst", {busy, m_tvalid, ovf}, 3'b111);
      #2 rstn = 1'b0;
      #1;
      check("rst_async", {m_tvalid, busy, ovf, m_tlast}, 4'b0000);
      step(); step();
      rstn = 1'b1;
      step();
      e = '{10, 0, 0, 1'b0, 10, 1'b0};
      run_rec(e);

      // maximum delay
      got_q.delete();
      m_tready = 1'b1;
      t0 = cyc;
      trig = 1'b1; rxsmps = 16'd2; rxdly = 16'hFFFF;
      step();
      trig = 1'b0;
      while (cyc < t0 + 65536) step();
      check("dlymax_pre", {busy, m_tvalid}, 2'b10);
      step();
      check("dlymax_word", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, DW'(t0 + 65536)});
      for (int k = 0; k < 20 && busy; k++) step();
      check("dlymax_count", got_q.size(), 2);

      // randomized records with stalls, extra trigs and zero-length trigs
      for (int r = 0; r < 30; r++) begin
         n = int'($urandom_range(1, 40));
         d = int'($urandom_range(0, 12));
         stall = ($urandom % 3 == 0) ? int'($urandom_range(10, 40)) : 0;
         if ($urandom % 4 == 0) begin
            trig = 1'b1; rxsmps = 16'd0; rxdly = CW'($urandom);
            step();
            trig = 1'b0;
         end
         trig = 1'b1; rxsmps = CW'(n); rxdly = CW'(d);
         m_tready = 1'($urandom % 2);
         step();
         for (int k = 0; k < 3000 && busy; k++) begin
            m_tready = (k + 1 >= stall) && ($urandom % 4 != 0);
            if ($urandom % 8 == 0) begin
               trig = 1'b1;
               rxsmps = CW'($urandom_range(1, 50));
               rxdly = CW'($urandom_range(0, 5));
            end else begin
               trig = 1'b0;
            end
            step();
         end
         trig = 1'b0;
         check("rand_done", busy, 1'b0);
         repeat ($urandom_range(0, 3)) begin
            m_tready = 1'($urandom % 2);
            step();
         end
      end

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
